gate_deadtime: RTL and testbench
================================

GATE_DEADTIME -- requirements
Module: gate_deadtime

Interface
REQ-001 Parameter DT_W, default 8, width of the dead-time configuration and counter.
REQ-002 Parameter MIN_DT, default 2, minimum enforced dead-time in clk cycles.
REQ-003 clk  in  1  system clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 k_req  in  4  raw PWM gate requests; [0]/[1] form leg A (upper/lower), [2]/[3] form leg B.
REQ-006 dt_cfg  in  DT_W  dead-time in clk cycles; sampled whenever a leg enters DT.
REQ-007 fault  in  1  global fault, active-high.
REQ-008 col  in  4  per-gate desaturation feedback, active-high.
REQ-009 fault_clr  in  1  single-cycle lockout clear request.
REQ-010 g  out  4  registered gate drives, [i] corresponds to k_req[i].
REQ-011 locked  out  1  high while in lockout.
REQ-012 flt_src  out  5  latched fault cause: [4] global fault, [3:0] col per gate.
REQ-013 st_err  out  1  one-cycle pulse when both requests of a leg are high.

Function
REQ-014 Each leg SHALL run an independent FSM with states OFF, DT, U_ON, L_ON; lockout is global.
REQ-015 OFF: both leg gates 0; upper-only request goes to DT with target upper; lower-only request goes to DT with target lower; none or both requests: stay in OFF.
REQ-016 DT: gates 0; counter counts dt_eff = max(dt_cfg, MIN_DT) cycles, then enters the target ON state if the target request is still the only one asserted; otherwise OFF.
REQ-017 dt_cfg SHALL be latched on DT entry; changes during DT have no effect until the next entry.
REQ-018 U_ON/L_ON: the target gate is 1 while its request stays the only one asserted; otherwise go to OFF, with the gate low on the next edge.
REQ-019 Latency: gate rises dt_eff+1 cycles after the request is first sampled high from OFF; gate falls 1 cycle after the request drops.
REQ-020 Both gates of one leg SHALL never be 1 in the same cycle, nor in consecutive cycles.
REQ-021 Both requests of a leg high: st_err pulses on every such cycle; the leg behaves as with no request.
REQ-022 col[i] is a fault only while g[i]=1; fault is unconditional.
REQ-023 Any fault SHALL, on the next edge, force all g to 0, set locked, and OR the active sources into flt_src; the FSMs go to OFF.
REQ-024 While locked, further sources OR into flt_src; k_req is ignored.
REQ-025 fault_clr while locked with fault=0 clears locked and flt_src on the next edge; otherwise fault_clr is ignored.
REQ-026 Fault and fault_clr in the same cycle: fault wins and the block stays locked.
REQ-027 dt_cfg=0 or 1 SHALL behave as MIN_DT; dt_cfg all-ones SHALL count fully without wrap.

Reset
REQ-028 rst SHALL set g=0, locked=0, flt_src=0, st_err=0, all FSMs OFF and all counters 0; rst overrides fault and the request inputs.
REQ-029 rst asserted mid-DT or mid-ON SHALL drop the gates on the next edge; after release, a turn-on SHALL take a full dead-time.

Configuration
REQ-030 Macro GATE_DESAT_FILTER_EN defined: col[i] SHALL be high for 4 consecutive cycles while g[i]=1 before it counts as a fault; the filter count resets when col[i]=0 or g[i]=0.
REQ-031 Macro GATE_DESAT_FILTER_EN undefined: a single cycle of col[i]&g[i] is a fault.

Structure
REQ-032 A shared package SHALL hold the leg state enum, the MIN_DT default and the flt_src bit indices.
REQ-033 Sub-module dt_leg SHALL implement one leg FSM plus counter and SHALL be instantiated twice; the lockout, flt_src and filter logic sit in gate_deadtime.

Verification
REQ-034 dt_cfg=5, k_req=0001 held: g[0] rises 6 cycles after the first sample; drop k_req: g[0]=0 one cycle later.
REQ-035 k_req 0001 then 0010 with no gap, dt_cfg=3: g[0] falls, g[1] rises 4 cycles after the change; g[0]&g[1] is never 1.
REQ-036 k_req=0011 for 3 cycles: st_err=1 on all 3 cycles, g[1:0]=00.
REQ-037 g[2]=1, col[2] high 2 cycles: with the filter enabled, no lock; without it, locked=1, flt_src=00100, g=0.
REQ-038 fault pulse then fault_clr while fault=1: still locked; fault_clr after fault=0: locked=0, flt_src=0.
REQ-039 dt_cfg=0, k_req=0100: g[2] rises 3 cycles after the sample; rst asserted mid-DT: g=0 and a full dead-time is required after release.

Source files
------------

// File: rtl/gate_deadtime_pkg.sv
// gate_deadtime_pkg
// Shared definitions for the gate dead-time block: the per-leg FSM state
// encoding, the default minimum dead-time and the flt_src bit layout.
package gate_deadtime_pkg;

    // Per-leg state. StUOn/StLOn drive the upper/lower gate of the leg.
    typedef enum logic [1:0] {
        StOff = 2'd0,
        StDt  = 2'd1,
        StUOn = 2'd2,
        StLOn = 2'd3
    } leg_state_t;

    // Default minimum dead-time in clk cycles.
    localparam int unsigned MIN_DT_DEF = 2;

    // flt_src layout: [FLT_GLOBAL] global fault, [FLT_COL_MSB:FLT_COL_LSB] per-gate desat.
    localparam int unsigned FLT_GLOBAL  = 4;
    localparam int unsigned FLT_COL_MSB = 3;
    localparam int unsigned FLT_COL_LSB = 0;

endpackage

// File: rtl/gate_deadtime_dt_leg.sv
// dt_leg
// One half-bridge leg: OFF / DT / U_ON / L_ON state machine with a dead-time
// counter. A gate is only ever driven after a full dead-time with both gates
// low, so the two gates of the leg can never overlap or abut.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   i_force_off  lockout/fault: force OFF and drop both gates on the next edge
//   i_req_up     raw upper gate request
//   i_req_lo     raw lower gate request
//   i_dt_cfg     dead-time in cycles, latched on DT entry
//   o_g_up       registered upper gate drive
//   o_g_lo       registered lower gate drive
module dt_leg
    import gate_deadtime_pkg::*;
#(
    parameter int unsigned DT_W   = 8,
    parameter int unsigned MIN_DT = MIN_DT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_force_off,
    input  logic            i_req_up,
    input  logic            i_req_lo,
    input  logic [DT_W-1:0] i_dt_cfg,
    output logic            o_g_up,
    output logic            o_g_lo
);

    localparam logic [DT_W-1:0] MIN_DT_V = DT_W'(MIN_DT);

    leg_state_t      r_state;
    leg_state_t      w_state_d;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_cnt_d;
    logic [DT_W-1:0] r_dt;
    logic [DT_W-1:0] w_dt_d;
    logic            r_tgt_up;
    logic            w_tgt_up_d;
    logic            r_g_up;
    logic            r_g_lo;

    logic            w_up_only;
    logic            w_lo_only;
    logic [DT_W-1:0] w_dt_eff;

    assign w_up_only = i_req_up & ~i_req_lo;
    assign w_lo_only = i_req_lo & ~i_req_up;
    assign w_dt_eff  = (i_dt_cfg < MIN_DT_V) ? MIN_DT_V : i_dt_cfg;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_dt_d     = r_dt;
        w_tgt_up_d = r_tgt_up;

        case (r_state)
            StOff: begin
                if (w_up_only || w_lo_only) begin
                    w_state_d  = StDt;
                    w_tgt_up_d = w_up_only;
                    w_cnt_d    = '0;
                    w_dt_d     = w_dt_eff;
                end
            end
            StDt: begin
                // Equality stop: an all-ones dead-time counts fully, never wraps.
                if (r_cnt == r_dt) begin
                    if (r_tgt_up && w_up_only) begin
                        w_state_d = StUOn;
                    end else if (!r_tgt_up && w_lo_only) begin
                        w_state_d = StLOn;
                    end else begin
                        w_state_d = StOff;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StUOn: begin
                // A direct hand-over to the opposite gate still passes through
                // a full dead-time, just without an extra OFF cycle.
                if (w_lo_only) begin
                    w_state_d  = StDt;
                    w_tgt_up_d = 1'b0;
                    w_cnt_d    = '0;
                    w_dt_d     = w_dt_eff;
                end else if (!w_up_only) begin
                    w_state_d = StOff;
                end
            end
            StLOn: begin
                if (w_up_only) begin
                    w_state_d  = StDt;
                    w_tgt_up_d = 1'b1;
                    w_cnt_d    = '0;
                    w_dt_d     = w_dt_eff;
                end else if (!w_lo_only) begin
                    w_state_d = StOff;
                end
            end
            default: begin
                w_state_d = StOff;
            end
        endcase

        if (i_force_off) begin
            w_state_d = StOff;
        end
        if (w_state_d != StDt) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StOff;
            r_cnt    <= '0;
            r_dt     <= '0;
            r_tgt_up <= 1'b0;
            r_g_up   <= 1'b0;
            r_g_lo   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_dt     <= w_dt_d;
            r_tgt_up <= w_tgt_up_d;
            r_g_up   <= (w_state_d == StUOn);
            r_g_lo   <= (w_state_d == StLOn);
        end
    end

    assign o_g_up = r_g_up;
    assign o_g_lo = r_g_lo;

endmodule

// File: rtl/gate_deadtime.sv
// gate_deadtime
// Dead-time inserting gate driver for two half-bridge legs with a global
// fault lockout. Leg A is k_req[1:0] (upper/lower), leg B is k_req[3:2].
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, overrides everything
//   k_req      raw PWM gate requests
//   dt_cfg     dead-time in cycles (values below MIN_DT act as MIN_DT)
//   fault      global fault, active-high
//   col        per-gate desaturation feedback, active-high
//   fault_clr  single-cycle lockout clear request
//   g          registered gate drives
//   locked     high while in lockout
//   flt_src    latched fault cause: [4] global fault, [3:0] desat per gate
//   st_err     registered pulse for each cycle a leg has both requests high
//
// Build option: define GATE_DESAT_FILTER_EN to require col[i] high for four
// consecutive cycles while g[i]=1 before it trips; otherwise one cycle trips.
module gate_deadtime
    import gate_deadtime_pkg::*;
#(
    parameter int unsigned DT_W   = 8,
    parameter int unsigned MIN_DT = MIN_DT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      k_req,
    input  logic [DT_W-1:0] dt_cfg,
    input  logic            fault,
    input  logic [3:0]      col,
    input  logic            fault_clr,
    output logic [3:0]      g,
    output logic            locked,
    output logic [4:0]      flt_src,
    output logic            st_err
);

    logic [3:0] w_g;
    logic [3:0] w_col_hit;
    logic [3:0] w_col_flt;
    logic [4:0] w_src;
    logic       w_trip;
    logic       w_force_off;
    logic       w_shoot;

    logic       r_locked;
    logic [4:0] r_flt_src;
    logic       r_st_err;

    // Desat only means something while the gate is actually driven.
    assign w_col_hit = col & w_g;

`ifdef GATE_DESAT_FILTER_EN
    logic [3:0][1:0] r_filt;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || !w_col_hit[i]) begin
                r_filt[i] <= 2'd0;
            end else if (r_filt[i] != 2'd3) begin
                r_filt[i] <= r_filt[i] + 2'd1;
            end
        end
    end

    // Three qualified cycles already counted, this is the fourth.
    always_comb begin
        w_col_flt = '0;
        for (int i = 0; i < 4; i++) begin
            w_col_flt[i] = w_col_hit[i] & (r_filt[i] == 2'd3);
        end
    end
`else
    assign w_col_flt = w_col_hit;
`endif

    always_comb begin
        w_src = '0;
        w_src[FLT_GLOBAL] = fault;
        w_src[FLT_COL_MSB:FLT_COL_LSB] = w_col_flt;
    end

    assign w_trip      = |w_src;
    assign w_force_off = r_locked | w_trip;
    assign w_shoot     = (k_req[0] & k_req[1]) | (k_req[2] & k_req[3]);

    dt_leg #(
        .DT_W   (DT_W),
        .MIN_DT (MIN_DT)
    ) u_leg_a (
        .clk         (clk),
        .rst         (rst),
        .i_force_off (w_force_off),
        .i_req_up    (k_req[0]),
        .i_req_lo    (k_req[1]),
        .i_dt_cfg    (dt_cfg),
        .o_g_up      (w_g[0]),
        .o_g_lo      (w_g[1])
    );

    dt_leg #(
        .DT_W   (DT_W),
        .MIN_DT (MIN_DT)
    ) u_leg_b (
        .clk         (clk),
        .rst         (rst),
        .i_force_off (w_force_off),
        .i_req_up    (k_req[2]),
        .i_req_lo    (k_req[3]),
        .i_dt_cfg    (dt_cfg),
        .o_g_up      (w_g[2]),
        .o_g_lo      (w_g[3])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked  <= 1'b0;
            r_flt_src <= '0;
            r_st_err  <= 1'b0;
        end else begin
            // A live source always beats a clear request.
            if (w_trip) begin
                r_locked  <= 1'b1;
                r_flt_src <= r_flt_src | w_src;
            end else if (r_locked && fault_clr) begin
                r_locked  <= 1'b0;
                r_flt_src <= '0;
            end
            // Requests are ignored while locked, including the overlap check.
            r_st_err <= w_shoot & ~r_locked;
        end
    end

    assign g       = w_g;
    assign locked  = r_locked;
    assign flt_src = r_flt_src;
    assign st_err  = r_st_err;

endmodule

// File: tb/tb_gate_deadtime.sv
// tb_gate_deadtime
// Directed bench for gate_deadtime. Each clock cycle the expected outputs are
// pushed to a scoreboard queue while the stimulus is applied, then popped and
// compared 1 time unit after the rising edge.
module tb_gate_deadtime;

    logic       clk;
    logic       rst;
    logic [3:0] k_req;
    logic [7:0] dt_cfg;
    logic       fault;
    logic [3:0] col;
    logic       fault_clr;
    logic [3:0] g;
    logic       locked;
    logic [4:0] flt_src;
    logic       st_err;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic       locked;
        logic [4:0] flt;
        logic       st_err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    gate_deadtime #(
        .DT_W   (8),
        .MIN_DT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .k_req     (k_req),
        .dt_cfg    (dt_cfg),
        .fault     (fault),
        .col       (col),
        .fault_clr (fault_clr),
        .g         (g),
        .locked    (locked),
        .flt_src   (flt_src),
        .st_err    (st_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: queue the expectation, take the edge, compare the oldest entry.
    task automatic cyc(input string tag, input logic [3:0] eg, input logic el,
                       input logic [4:0] ef, input logic es);
        exp_t e;
        e.tag = tag; e.g = eg; e.locked = el; e.flt = ef; e.st_err = es;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, ".g"},       {28'd0, g},       {28'd0, e.g});
            check_val({e.tag, ".locked"},  {31'd0, locked},  {31'd0, e.locked});
            check_val({e.tag, ".flt_src"}, {27'd0, flt_src}, {27'd0, e.flt});
            check_val({e.tag, ".st_err"},  {31'd0, st_err},  {31'd0, e.st_err});
            check_val({e.tag, ".overlap"},
                      {31'd0, (g[0] & g[1]) | (g[2] & g[3])}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; k_req = 4'b0000; fault = 1'b0; col = 4'b0000; fault_clr = 1'b0;
        cyc("reset", 4'b0000, 1'b0, 5'b00000, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; k_req = 4'b0000; dt_cfg = 8'd0; fault = 1'b0; col = 4'b0000;
        fault_clr = 1'b0;
        @(posedge clk);
        #1;

        // Rise after dt+1 cycles; dt_cfg change mid-DT has no effect.
        do_reset();
        dt_cfg = 8'd5; k_req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            cyc("dt5_wait", 4'b0000, 1'b0, 5'b0, 1'b0);
            if (i == 0) dt_cfg = 8'd0;
        end
        cyc("dt5_on", 4'b0001, 1'b0, 5'b0, 1'b0);
        cyc("dt5_hold", 4'b0001, 1'b0, 5'b0, 1'b0);
        k_req = 4'b0000;
        cyc("dt5_off", 4'b0000, 1'b0, 5'b0, 1'b0);

        // Upper to lower hand-over with no gap, dt_cfg=3.
        do_reset();
        dt_cfg = 8'd3; k_req = 4'b0001;
        for (int i = 0; i < 4; i++) cyc("hand_wait_u", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("hand_u_on", 4'b0001, 1'b0, 5'b0, 1'b0);
        k_req = 4'b0010;
        for (int i = 0; i < 4; i++) cyc("hand_wait_l", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("hand_l_on", 4'b0010, 1'b0, 5'b0, 1'b0);
        k_req = 4'b0000;
        cyc("hand_off", 4'b0000, 1'b0, 5'b0, 1'b0);

        // Shoot-through request on leg A for three cycles.
        do_reset();
        dt_cfg = 8'd2; k_req = 4'b0011;
        for (int i = 0; i < 3; i++) cyc("st_err", 4'b0000, 1'b0, 5'b0, 1'b1);
        k_req = 4'b0000;
        cyc("st_err_end", 4'b0000, 1'b0, 5'b0, 1'b0);

        // Desat on gate 2.
        do_reset();
        dt_cfg = 8'd2; k_req = 4'b0100;
        for (int i = 0; i < 3; i++) cyc("desat_wait", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("desat_on", 4'b0100, 1'b0, 5'b0, 1'b0);
        col = 4'b0100;
`ifdef GATE_DESAT_FILTER_EN
        cyc("desat_f1", 4'b0100, 1'b0, 5'b0, 1'b0);
        cyc("desat_f2", 4'b0100, 1'b0, 5'b0, 1'b0);
        col = 4'b0000;
        cyc("desat_gap", 4'b0100, 1'b0, 5'b0, 1'b0);
        col = 4'b0100;
        for (int i = 0; i < 3; i++) cyc("desat_f_cnt", 4'b0100, 1'b0, 5'b0, 1'b0);
        cyc("desat_f_trip", 4'b0000, 1'b1, 5'b00100, 1'b0);
`else
        cyc("desat_trip", 4'b0000, 1'b1, 5'b00100, 1'b0);
        cyc("desat_held", 4'b0000, 1'b1, 5'b00100, 1'b0);
`endif
        col = 4'b0000; k_req = 4'b0000;
        cyc("desat_locked", 4'b0000, 1'b1, 5'b00100, 1'b0);
        fault_clr = 1'b1;
        cyc("desat_clr", 4'b0000, 1'b0, 5'b00000, 1'b0);
        fault_clr = 1'b0;

        // Global fault, clear rejected while fault is high, then accepted.
        do_reset();
        col = 4'b0010;
        cyc("col_gate_off", 4'b0000, 1'b0, 5'b0, 1'b0);
        col = 4'b0000; dt_cfg = 8'd2; k_req = 4'b0001;
        for (int i = 0; i < 3; i++) cyc("flt_wait", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("flt_on", 4'b0001, 1'b0, 5'b0, 1'b0);
        fault = 1'b1;
        cyc("flt_trip", 4'b0000, 1'b1, 5'b10000, 1'b0);
        fault = 1'b0; k_req = 4'b0011;
        cyc("flt_ignore_req", 4'b0000, 1'b1, 5'b10000, 1'b0);
        fault = 1'b1; fault_clr = 1'b1; k_req = 4'b0000;
        cyc("flt_clr_lose", 4'b0000, 1'b1, 5'b10000, 1'b0);
        fault = 1'b0;
        cyc("flt_clr_ok", 4'b0000, 1'b0, 5'b00000, 1'b0);
        fault_clr = 1'b0;
        fault_clr = 1'b1;
        cyc("flt_clr_idle", 4'b0000, 1'b0, 5'b00000, 1'b0);
        fault_clr = 1'b0;

        // dt_cfg=0 acts as MIN_DT; reset mid-DT and mid-ON.
        do_reset();
        dt_cfg = 8'd0; k_req = 4'b0100;
        for (int i = 0; i < 3; i++) cyc("dt0_wait", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("dt0_on", 4'b0100, 1'b0, 5'b0, 1'b0);
        rst = 1'b1;
        cyc("rst_mid_on", 4'b0000, 1'b0, 5'b0, 1'b0);
        rst = 1'b0;
        cyc("rst_dt_a", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("rst_dt_b", 4'b0000, 1'b0, 5'b0, 1'b0);
        rst = 1'b1; fault = 1'b1;
        cyc("rst_mid_dt", 4'b0000, 1'b0, 5'b0, 1'b0);
        rst = 1'b0; fault = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rst_full_dt", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("rst_dt_on", 4'b0100, 1'b0, 5'b0, 1'b0);
        k_req = 4'b0000;
        cyc("rst_dt_off", 4'b0000, 1'b0, 5'b0, 1'b0);

        // All-ones dead-time on the lower gate of leg B: 256 cycles, no wrap.
        do_reset();
        dt_cfg = 8'hFF; k_req = 4'b1000;
        for (int i = 0; i < 256; i++) cyc("dtmax_wait", 4'b0000, 1'b0, 5'b0, 1'b0);
        cyc("dtmax_on", 4'b1000, 1'b0, 5'b0, 1'b0);
        k_req = 4'b0000;
        cyc("dtmax_off", 4'b0000, 1'b0, 5'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
